// File: rtl/obs_pkg.sv
// rtl/obs_pkg.sv - shared types and constants for the obstacle sprite engine
// Contents:
//   state_e      engine FSM states
//   dir_e        vertical travel direction
//   COLOUR_ERASE background colour used when erasing
//   SCREEN_W/H   VGA adapter resolution
//   lfsr_taps()  maximal-length Fibonacci tap masks for small widths
package obs_pkg;

  typedef enum logic [2:0] {
    ST_SPAWN,
    ST_WAIT,
    ST_ERASE,
    ST_MOVE,
    ST_DRAW
  } state_e;

  typedef enum logic {
    DIR_DOWN,
    DIR_UP
  } dir_e;

  localparam logic [2:0] COLOUR_ERASE = 3'd0;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  // Tap mask: bit i set means register bit i feeds the XOR.
  function automatic logic [31:0] lfsr_taps(input int width);
    case (width)
      2:       return 32'h0000_0003;
      3:       return 32'h0000_0006;
      4:       return 32'h0000_000C;
      5:       return 32'h0000_0014;
      6:       return 32'h0000_0030;
      7:       return 32'h0000_0060;
      8:       return 32'h0000_00B8;
      default: return 32'h0000_0003;
    endcase
  endfunction

endpackage

// File: rtl/obs_lfsr.sv
// rtl/obs_lfsr.sv - free-running Fibonacci LFSR
// Ports:
//   clock   in           system clock
//   resetn  in           asynchronous active-low reset (loads SEED)
//   lfsr_o  out [WIDTH]  current register value
module obs_lfsr
  import obs_pkg::*;
#(
  parameter int               WIDTH = 5,
  parameter logic [WIDTH-1:0] SEED  = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(lfsr_taps(WIDTH))
) (
  input  logic             clock,
  input  logic             resetn,
  output logic [WIDTH-1:0] lfsr_o
);

  logic [WIDTH-1:0] lfsr_q;
  logic             feedback;

  assign feedback = ^(lfsr_q & TAPS);
  assign lfsr_o   = lfsr_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= {lfsr_q[WIDTH-2:0], feedback};
    end
  end

endmodule

// File: rtl/obs_sprite_engine.sv
// rtl/obs_sprite_engine.sv - moving obstacle sprite with erase/move/redraw pixel stream
// Optional build macro: OBS_RESPAWN_EN (down-only travel, respawn at top with new x).
// Ports:
//   clock       in       system clock
//   resetn      in       asynchronous active-low reset
//   enable      in       frame/tick counters run while high
//   plot_ready  in       adapter accepts the presented pixel
//   plot        out      pixel write valid
//   x, y        out 8/7  pixel coordinates
//   colour      out 3    pixel colour
//   busy        out      high in SPAWN/ERASE/MOVE/DRAW
//   step_done   out      one-cycle pulse after a DRAW pass
//   pos_x/pos_y out 8/7  sprite top-left corner
module obs_sprite_engine
  import obs_pkg::*;
#(
  parameter int         OBJ_W           = 2,
  parameter int         OBJ_H           = 16,
  parameter logic [2:0] OBJ_COLOUR      = 3'd1,
  parameter int         TICKS_PER_FRAME = 833333,
  parameter int         FRAMES_PER_STEP = 10,
  parameter int         STEP            = 1,
  parameter int         Y_MIN           = 0,
  parameter int         Y_MAX           = 104,
  parameter int         X_BASE          = 64,
  parameter int         X_RAND_BITS     = 5
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       enable,
  input  logic       plot_ready,
  output logic       plot,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       busy,
  output logic       step_done,
  output logic [7:0] pos_x,
  output logic [6:0] pos_y
);

  localparam int TW  = $clog2(TICKS_PER_FRAME + 1);
  localparam int FW  = $clog2(FRAMES_PER_STEP + 1);
  localparam int PXW = $clog2(OBJ_W + 1);
  localparam int PYW = $clog2(OBJ_H + 1);

  // The sprite must stay fully on screen for every reachable position.
  if (X_BASE + (1 << X_RAND_BITS) + OBJ_W - 2 > SCREEN_W - 1) begin : g_x_range_err
    $error("obs_sprite_engine: sprite x range exceeds screen width");
  end
  if (Y_MAX + OBJ_H - 1 > SCREEN_H - 1) begin : g_y_range_err
    $error("obs_sprite_engine: sprite y range exceeds screen height");
  end

  state_e             state_q;
  dir_e               dir_q;
  logic [TW-1:0]      tick_q;
  logic [FW-1:0]      frame_q;
  logic [PXW-1:0]     px_q;
  logic [PYW-1:0]     py_q;
  logic               plot_q, busy_q, step_done_q;
  logic [7:0]         x_q, pos_x_q;
  logic [6:0]         y_q, pos_y_q;
  logic [2:0]         colour_q;

  logic [X_RAND_BITS-1:0] lfsr_val;
  logic [7:0]             spawn_x;
  logic [8:0]             y_plus;
  logic [7:0]             pos_x_d;
  logic [6:0]             pos_y_d;
  dir_e                   dir_d;
  logic                   last_col, last_pix;

  obs_lfsr #(
    .WIDTH(X_RAND_BITS)
  ) u_lfsr (
    .clock (clock),
    .resetn(resetn),
    .lfsr_o(lfsr_val)
  );

  assign spawn_x  = 8'(X_BASE) + 8'(lfsr_val);
  assign y_plus   = {2'b00, pos_y_q} + 9'(STEP);
  assign last_col = (px_q == PXW'(OBJ_W - 1));
  assign last_pix = last_col && (py_q == PYW'(OBJ_H - 1));

  // Position update applied in MOVE.
  always_comb begin
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    dir_d   = dir_q;
`ifdef OBS_RESPAWN_EN
    if (y_plus > 9'(Y_MAX)) begin
      pos_y_d = 7'(Y_MIN);
      pos_x_d = spawn_x;
    end else begin
      pos_y_d = y_plus[6:0];
    end
`else
    if (dir_q == DIR_DOWN) begin
      if (y_plus >= 9'(Y_MAX)) begin
        pos_y_d = 7'(Y_MAX);
        dir_d   = DIR_UP;
      end else begin
        pos_y_d = y_plus[6:0];
      end
    end else begin
      if ({2'b00, pos_y_q} <= 9'(Y_MIN + STEP)) begin
        pos_y_d = 7'(Y_MIN);
        dir_d   = DIR_DOWN;
      end else begin
        pos_y_d = pos_y_q - 7'(STEP);
      end
    end
`endif
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_SPAWN;
      dir_q       <= DIR_DOWN;
      tick_q      <= '0;
      frame_q     <= '0;
      px_q        <= '0;
      py_q        <= '0;
      plot_q      <= 1'b0;
      x_q         <= 8'd0;
      y_q         <= 7'd0;
      colour_q    <= 3'd0;
      busy_q      <= 1'b1;
      step_done_q <= 1'b0;
      pos_x_q     <= 8'(X_BASE);
      pos_y_q     <= 7'(Y_MIN);
    end else begin
      step_done_q <= 1'b0;
      case (state_q)
        ST_SPAWN: begin
          pos_x_q  <= spawn_x;
          pos_y_q  <= 7'(Y_MIN);
          dir_q    <= DIR_DOWN;
          px_q     <= '0;
          py_q     <= '0;
          plot_q   <= 1'b1;
          x_q      <= spawn_x;
          y_q      <= 7'(Y_MIN);
          colour_q <= OBJ_COLOUR;
          state_q  <= ST_DRAW;
        end
        ST_WAIT: begin
          if (enable) begin
            if (tick_q == TW'(TICKS_PER_FRAME - 1)) begin
              tick_q <= '0;
              if (frame_q == FW'(FRAMES_PER_STEP - 1)) begin
                frame_q  <= '0;
                busy_q   <= 1'b1;
                px_q     <= '0;
                py_q     <= '0;
                plot_q   <= 1'b1;
                x_q      <= pos_x_q;
                y_q      <= pos_y_q;
                colour_q <= COLOUR_ERASE;
                state_q  <= ST_ERASE;
              end else begin
                frame_q <= frame_q + 1'b1;
              end
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
        end
        ST_ERASE, ST_DRAW: begin
          // plot is high for the whole pass, so acceptance is just plot_ready.
          if (plot_ready) begin
            if (last_pix) begin
              plot_q <= 1'b0;
              if (state_q == ST_ERASE) begin
                state_q <= ST_MOVE;
              end else begin
                state_q     <= ST_WAIT;
                busy_q      <= 1'b0;
                step_done_q <= 1'b1;
              end
            end else if (last_col) begin
              px_q <= '0;
              py_q <= py_q + 1'b1;
              x_q  <= pos_x_q;
              y_q  <= y_q + 7'd1;
            end else begin
              px_q <= px_q + 1'b1;
              x_q  <= x_q + 8'd1;
            end
          end
        end
        ST_MOVE: begin
          pos_x_q  <= pos_x_d;
          pos_y_q  <= pos_y_d;
          dir_q    <= dir_d;
          px_q     <= '0;
          py_q     <= '0;
          plot_q   <= 1'b1;
          x_q      <= pos_x_d;
          y_q      <= pos_y_d;
          colour_q <= OBJ_COLOUR;
          state_q  <= ST_DRAW;
        end
        default: state_q <= ST_SPAWN;
      endcase
    end
  end

  assign plot      = plot_q;
  assign x         = x_q;
  assign y         = y_q;
  assign colour    = colour_q;
  assign busy      = busy_q;
  assign step_done = step_done_q;
  assign pos_x     = pos_x_q;
  assign pos_y     = pos_y_q;

endmodule

// File: tb/tb_obs_sprite_engine.sv
// tb/tb_obs_sprite_engine.sv - self-checking bench for obs_sprite_engine
module tb_obs_sprite_engine;

  localparam int         OW    = 2;
  localparam int         OH    = 4;
  localparam logic [2:0] COL   = 3'd1;
  localparam int         XBASE = 64;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       enable = 1'b0;
  logic       plot_ready = 1'b1;
  logic       plot, busy, step_done;
  logic [7:0] x, pos_x;
  logic [6:0] y, pos_y;
  logic [2:0] colour;

  always #5 clock = ~clock;

  obs_sprite_engine #(
    .OBJ_W(OW), .OBJ_H(OH), .OBJ_COLOUR(COL), .TICKS_PER_FRAME(4),
    .FRAMES_PER_STEP(2), .STEP(1), .Y_MIN(0), .Y_MAX(3),
    .X_BASE(XBASE), .X_RAND_BITS(5)
  ) dut (
    .clock(clock), .resetn(resetn), .enable(enable), .plot_ready(plot_ready),
    .plot(plot), .x(x), .y(y), .colour(colour), .busy(busy),
    .step_done(step_done), .pos_x(pos_x), .pos_y(pos_y)
  );

  typedef struct packed {
    logic [7:0] px;
    logic [6:0] py;
    logic [2:0] pc;
  } pix_t;

  typedef struct {
    int ready_mode;  // 0 = always ready, 1 = toggle, 2 = random
    bit dis_mid;     // drop enable once the erase pass has started
    int exp_y;
  } step_vec_t;

  int   n_chk = 0;
  int   n_fail = 0;
  int   mode = 0;
  int   plot_cyc = 0;
  int   sd_cnt = 0;
  pix_t acc_q[$];
  pix_t exp_q[$];
  int   acc_base = 0;
  bit   hold_prev = 0;
  pix_t prev_pix;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock: drive ready after the edge, sample outputs on the falling edge.
  task automatic tick();
    @(posedge clock);
    #1;
    case (mode)
      1:       plot_ready = ~plot_ready;
      2:       plot_ready = 1'($urandom_range(0, 1));
      default: plot_ready = 1'b1;
    endcase
    @(negedge clock);
    if (resetn) begin
      if (plot) plot_cyc++;
      if (hold_prev) begin
        chk("held_pixel_plot", int'(plot), 1);
        chk("held_pixel_value", int'({x, y, colour}), int'(prev_pix));
      end
      if (plot && plot_ready) acc_q.push_back({x, y, colour});
      hold_prev = plot && !plot_ready;
      prev_pix  = {x, y, colour};
      if (step_done) sd_cnt++;
    end
  endtask

  task automatic wait_step(input string name);
    int start = sd_cnt;
    int n = 0;
    while (sd_cnt == start && n < 500) begin
      tick();
      n++;
    end
    if (sd_cnt == start) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic add_pass(input int bx, input int by, input logic [2:0] c);
    for (int r = 0; r < OH; r++)
      for (int cx = 0; cx < OW; cx++)
        exp_q.push_back({8'(bx + cx), 7'(by + r), c});
  endtask

  task automatic check_pixels(input string name);
    int got = acc_q.size() - acc_base;
    int good = 0;
    chk({name, "_count"}, got, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got; i++)
      if (acc_q[acc_base + i] == exp_q[i]) good++;
    chk({name, "_match"}, good, exp_q.size());
    exp_q.delete();
    acc_base = acc_q.size();
  endtask

  step_vec_t vec[9];
  int model_x, prev_y, n, snap, sd0;

  initial begin
`ifdef OBS_RESPAWN_EN
    vec[0] = '{0, 0, 1}; vec[1] = '{1, 0, 2}; vec[2] = '{2, 0, 3};
    vec[3] = '{0, 0, 0}; vec[4] = '{1, 0, 1}; vec[5] = '{2, 0, 2};
    vec[6] = '{0, 0, 3}; vec[7] = '{1, 0, 0}; vec[8] = '{0, 1, 1};
`else
    vec[0] = '{0, 0, 1}; vec[1] = '{1, 0, 2}; vec[2] = '{2, 0, 3};
    vec[3] = '{0, 0, 2}; vec[4] = '{1, 0, 1}; vec[5] = '{2, 0, 0};
    vec[6] = '{0, 0, 1}; vec[7] = '{1, 0, 2}; vec[8] = '{0, 1, 3};
`endif

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_plot", int'(plot), 0);
    chk("rst_xy", int'({x, y}), 0);
    chk("rst_colour", int'(colour), 0);
    chk("rst_busy", int'(busy), 1);
    chk("rst_step_done", int'(step_done), 0);
    chk("rst_pos_x", int'(pos_x), XBASE);
    chk("rst_pos_y", int'(pos_y), 0);

    // Spawn: LFSR is all-ones when sampled, so x = 64 + 31.
    @(posedge clock);
    #2 resetn = 1'b1;
    model_x = XBASE + 31;
    prev_y  = 0;
    snap = plot_cyc;
    wait_step("spawn");
    add_pass(model_x, 0, COL);
    check_pixels("spawn_pixels");
    chk("spawn_plot_cycles", plot_cyc - snap, OW * OH);
    chk("spawn_pos_x", int'(pos_x), model_x);
    chk("spawn_pos_y", int'(pos_y), 0);
    tick();
    chk("wait_busy", int'(busy), 0);

    // Idle in WAIT with enable low: nothing is plotted.
    snap = plot_cyc;
    repeat (50) tick();
    chk("idle_no_plot", plot_cyc - snap, 0);

    for (int i = 0; i < 9; i++) begin
      mode = vec[i].ready_mode;
      snap = plot_cyc;
      enable = 1'b1;
      if (i == 0) begin
        n = 0;
        do begin
          tick();
          n++;
        end while (!plot && n < 100);
        chk("wait_latency", n, 8);
      end
      if (vec[i].dis_mid) begin
        n = 0;
        while (!(plot && colour == 3'd0) && n < 100) begin
          tick();
          n++;
        end
        enable = 1'b0;
      end
      wait_step($sformatf("step%0d", i));
      add_pass(model_x, prev_y, 3'd0);
`ifdef OBS_RESPAWN_EN
      if (vec[i].exp_y < prev_y && acc_q.size() >= acc_base + 9) begin
        chk("respawn_x_range",
            int'(acc_q[acc_base + 8].px >= 8'(XBASE) && acc_q[acc_base + 8].px <= 8'(XBASE + 31)), 1);
        model_x = int'(acc_q[acc_base + 8].px);
      end
`endif
      add_pass(model_x, vec[i].exp_y, COL);
      check_pixels($sformatf("step%0d_pixels", i));
      chk($sformatf("step%0d_pos_y", i), int'(pos_y), vec[i].exp_y);
      if (mode == 0) chk($sformatf("step%0d_plot_cycles", i), plot_cyc - snap, 2 * OW * OH);
      if (mode == 1) chk($sformatf("step%0d_toggle_slow", i), int'(plot_cyc - snap >= 4 * OW * OH - 2), 1);
      prev_y = vec[i].exp_y;
    end

    // Enable held low after the interrupted step: counters frozen.
    mode = 0;
    snap = plot_cyc;
    repeat (50) tick();
    chk("freeze_no_plot", plot_cyc - snap, 0);

    // Reset while the fourth draw pixel is on the bus.
    enable = 1'b1;
    n = 0;
    while (acc_q.size() - acc_base < 2 * OW * OH - 5 && n < 200) begin
      tick();
      n++;
    end
    chk("pre_reset_draw_pixel", int'(plot && colour == COL), 1);
    resetn = 1'b0;
    #1;
    chk("midreset_plot", int'(plot), 0);
    chk("midreset_busy", int'(busy), 1);
    chk("midreset_pos_y", int'(pos_y), 0);
    hold_prev = 0;
    @(posedge clock);
    #2 resetn = 1'b1;
    acc_base = acc_q.size();
    sd0 = sd_cnt;
    wait_step("respawn_after_reset");
    chk("reset_spawn_pos_y", int'(pos_y), 0);
    chk("reset_spawn_x_range", int'(pos_x >= 8'(XBASE) && pos_x <= 8'(XBASE + 31)), 1);
    wait_step("first_step_after_reset");
    chk("reset_dir_down", int'(pos_y), 1);
    chk("reset_step_count", sd_cnt - sd0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
